// File: rtl/filter_relay_pkg.sv
// Shared state encoding and relay word layout for the filter relay driver.
// band_to_word builds the LPF/BPF/T-R relay word for one band code.
package filter_relay_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, SETTLE} relay_state_e;

  localparam int WORD_W   = 16;
  localparam int TR_BIT   = 15;
  localparam int LPF_LSB  = 0;
  localparam int BPF_BASE = 7;

  // Band 0 is the BPF bypass, so it sets no BPF relay.
  function automatic logic [WORD_W-1:0] band_to_word(input logic [2:0] band, input logic tr);
    logic [WORD_W-1:0] word;
    word = WORD_W'(1) << (LPF_LSB + int'(band));
    if (band != 3'd0) word = word | (WORD_W'(1) << (BPF_BASE + int'(band)));
    word[TR_BIT] = tr;
    return word;
  endfunction

endpackage

// File: rtl/relay_shifter.sv
// Serialises a relay word MSB first onto a 74HC595-style chain, then strobes rck.
// Runs in lockstep with the driver FSM: start in LOAD, latch_start/done end SHIFT/LATCH.
module relay_shifter
  import filter_relay_pkg::*;
#(
  parameter int SCK_DIV = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] word,
  output logic              sck,
  output logic              sdo,
  output logic              rck,
  output logic              latch_start,
  output logic              done
);

  localparam int DIV_W = $clog2(SCK_DIV + 1);
  localparam int BIT_W = $clog2(WORD_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);

  relay_state_e      state_q, state_d;
  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] shreg;
  logic              sck_q;
  logic              rck_q;
  logic              half_end;

  assign half_end    = (div_cnt == DIV_LAST);
  assign latch_start = (state_q == SHIFT) && sck_q && half_end && (bit_cnt == BIT_LAST);
  assign done        = (state_q == LATCH) && half_end;
  assign sck         = sck_q;
  assign sdo         = shreg[WORD_W-1];
  assign rck         = rck_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (latch_start) state_d = LATCH;
      LATCH:   if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The word only moves on the falling sck transition, so sdo holds through each high phase.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      sck_q   <= 1'b0;
      rck_q   <= 1'b0;
    end else begin
      case (state_q)
        SHIFT: begin
          if (half_end) begin
            div_cnt <= '0;
            sck_q   <= ~sck_q;
            if (sck_q) begin
              shreg   <= shreg << 1;
              bit_cnt <= bit_cnt + 1'b1;
              rck_q   <= (bit_cnt == BIT_LAST);
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        LATCH: begin
          if (half_end) begin
            div_cnt <= '0;
            rck_q   <= 1'b0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: begin
          div_cnt <= '0;
          bit_cnt <= '0;
          sck_q   <= 1'b0;
          rck_q   <= 1'b0;
          if (start) shreg <= word;
        end
      endcase
    end
  end

endmodule

// File: rtl/filter_relay_driver.sv
// Relay board driver: debounces the band code, sends changed relay words, waits out
// relay settling and keeps PTT off whenever the relays are not in their final state.
module filter_relay_driver
  import filter_relay_pkg::*;
#(
  parameter int SCK_DIV    = 8,
  parameter int SETTLE_CYC = 491520,
  parameter int BAND_HOLD  = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       run,
  input  logic [2:0] band,
  input  logic       ptt_in,
  output logic       ptt_out,
  output logic       tx_inhibit,
  output logic       busy,
  output logic       sck,
  output logic       sdo,
  output logic       rck,
  output logic [2:0] band_active
);

  localparam int SETTLE_W = $clog2(SETTLE_CYC + 1);
  localparam int HOLD_W   = $clog2(BAND_HOLD + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
  localparam logic [HOLD_W-1:0]   HOLD_MAX    = HOLD_W'(BAND_HOLD);

  relay_state_e        state_q, state_d;
  logic [2:0]          band_last;
  logic [2:0]          band_acc;
  logic [2:0]          frame_band;
  logic [2:0]          band_active_q;
  logic [HOLD_W-1:0]   hold_cnt, hold_next;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [WORD_W-1:0]   target, applied, frame_word;
  logic                ptt_eff, release_wanted;
  logic                ptt_out_q, ptt_out_next, tx_inhibit_q;
  logic                shift_latch, shift_done;

  assign ptt_eff        = ptt_in & run;
  assign target         = band_to_word(band_acc, ptt_eff);
  assign release_wanted = applied[TR_BIT] & ~target[TR_BIT];
  assign ptt_out_next   = ptt_eff & applied[TR_BIT] & (state_d == IDLE) & (target == applied);

  assign busy        = (state_q != IDLE);
  assign ptt_out     = ptt_out_q;
  assign tx_inhibit  = tx_inhibit_q;
  assign band_active = band_active_q;

  // The counter restarts at 1 on the first sample of a new value; saturation avoids wrap.
  always_comb begin
    hold_next = hold_cnt;
    if (band != band_last)       hold_next = HOLD_W'(1);
    else if (hold_cnt != HOLD_MAX) hold_next = hold_cnt + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      band_last <= '0;
      band_acc  <= '0;
      hold_cnt  <= '0;
    end else begin
      band_last <= band;
      hold_cnt  <= hold_next;
      if (hold_next == HOLD_MAX) band_acc <= band;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // On a PTT release the frame waits one cycle so ptt_out is already low before relays move.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if ((target != applied) && !(release_wanted && ptt_out_q)) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (shift_latch) state_d = LATCH;
      LATCH:   if (shift_done) state_d = SETTLE;
      SETTLE:  if (settle_cnt == SETTLE_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      applied       <= '1;
      frame_word    <= '0;
      frame_band    <= '0;
      band_active_q <= '0;
      settle_cnt    <= '0;
      ptt_out_q     <= 1'b0;
      tx_inhibit_q  <= 1'b0;
    end else begin
      if (state_q == LOAD) begin
        frame_word <= target;
        frame_band <= band_acc;
      end
      if ((state_q == SHIFT) && (state_d == LATCH)) begin
        applied       <= frame_word;
        band_active_q <= frame_band;
      end
      settle_cnt   <= (state_q == SETTLE) ? settle_cnt + 1'b1 : '0;
      ptt_out_q    <= ptt_out_next;
      tx_inhibit_q <= ptt_eff & ~ptt_out_next;
    end
  end

  relay_shifter #(
    .SCK_DIV (SCK_DIV)
  ) u_shifter (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (state_q == LOAD),
    .word        (target),
    .sck         (sck),
    .sdo         (sdo),
    .rck         (rck),
    .latch_start (shift_latch),
    .done        (shift_done)
  );

endmodule

// File: tb/tb_filter_relay_driver.sv
// Directed bench for filter_relay_driver with short timing (SCK_DIV=2, SETTLE_CYC=10, BAND_HOLD=4).
// A pin-level monitor reassembles each serial frame so word contents are checked from sck/sdo/rck.
module tb_filter_relay_driver;

  localparam int SCK_DIV    = 2;
  localparam int SETTLE_CYC = 10;
  localparam int BAND_HOLD  = 4;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       run     = 1'b0;
  logic       ptt_in  = 1'b0;
  logic [2:0] band    = 3'd0;
  logic       ptt_out, tx_inhibit, busy, sck, sdo, rck;
  logic [2:0] band_active;

  int checks     = 0;
  int failures   = 0;
  int rck_count  = 0;
  int rx_bits    = 0;
  int last_bits  = 0;
  int busy_run   = 0;
  int last_busy  = 0;
  int sdo_glitch = 0;
  logic [15:0] rx_word   = '0;
  logic [15:0] last_word = '0;
  logic sck_prev = 1'b0;
  logic rck_prev = 1'b0;
  logic sdo_prev = 1'b0;

  filter_relay_driver #(
    .SCK_DIV    (SCK_DIV),
    .SETTLE_CYC (SETTLE_CYC),
    .BAND_HOLD  (BAND_HOLD)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .run         (run),
    .band        (band),
    .ptt_in      (ptt_in),
    .ptt_out     (ptt_out),
    .tx_inhibit  (tx_inhibit),
    .busy        (busy),
    .sck         (sck),
    .sdo         (sdo),
    .rck         (rck),
    .band_active (band_active)
  );

  always #5 clock = ~clock;

  // Shift in sdo on each sck rise, capture the word on each rck rise, measure busy length.
  always @(negedge clock) begin
    if (!reset_n) begin
      rx_bits  = 0;
      busy_run = 0;
    end else begin
      if (sck && !sck_prev) begin
        rx_word = {rx_word[14:0], sdo};
        rx_bits++;
      end
      if (sck && sck_prev && (sdo !== sdo_prev)) sdo_glitch++;
      if (rck && !rck_prev) begin
        rck_count++;
        last_word = rx_word;
        last_bits = rx_bits;
        rx_bits   = 0;
      end
      if (busy) busy_run++;
      else if (busy_run != 0) begin
        last_busy = busy_run;
        busy_run  = 0;
      end
    end
    sck_prev = sck;
    rck_prev = rck;
    sdo_prev = sdo;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic p, input logic [2:0] b);
    run    = r;
    ptt_in = p;
    band   = b;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    $display("[TB] start");
    applyStimulus(1'b1, 1'b0, 3'd0);
    #2;
    checkOutput("rst_ptt_out", ptt_out, 0);
    checkOutput("rst_tx_inhibit", tx_inhibit, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_sck", sck, 0);
    checkOutput("rst_sdo", sdo, 0);
    checkOutput("rst_rck", rck, 0);
    checkOutput("rst_band_active", band_active, 0);
    tick(2);
    reset_n = 1'b1;

    // First frame after reset: band 0 word, busy exactly 77 cycles.
    tick(1);
    checkOutput("boot_load_busy", busy, 1);
    tick(76);
    checkOutput("boot_busy_last", busy, 1);
    tick(1);
    checkOutput("boot_busy_done", busy, 0);
    tick(2);
    checkOutput("boot_word", last_word, 16'h0001);
    checkOutput("boot_bits", last_bits, 16);
    checkOutput("boot_rck_count", rck_count, 1);
    checkOutput("boot_busy_len", last_busy, 77);
    checkOutput("boot_ptt_out", ptt_out, 0);
    checkOutput("boot_band_active", band_active, 0);

    // Band 0 -> 4: accepted after four samples, LOAD on the fifth edge.
    applyStimulus(1'b1, 1'b0, 3'd4);
    tick(4);
    checkOutput("b4_hold_idle", busy, 0);
    tick(1);
    checkOutput("b4_load", busy, 1);
    tick(64);
    checkOutput("b4_pre_latch_band", band_active, 0);
    checkOutput("b4_pre_latch_rck", rck, 0);
    tick(1);
    checkOutput("b4_latch_band", band_active, 4);
    checkOutput("b4_latch_rck", rck, 1);
    tick(15);
    checkOutput("b4_word", last_word, 16'h0810);
    checkOutput("b4_busy_len", last_busy, 77);

    // PTT on at band 4: inhibit until the T/R frame has settled.
    applyStimulus(1'b1, 1'b1, 3'd4);
    tick(1);
    checkOutput("ptt_on_busy", busy, 1);
    checkOutput("ptt_on_inhibit", tx_inhibit, 1);
    checkOutput("ptt_on_out", ptt_out, 0);
    tick(76);
    checkOutput("ptt_settle_out", ptt_out, 0);
    checkOutput("ptt_settle_inhibit", tx_inhibit, 1);
    tick(1);
    checkOutput("ptt_keyed_out", ptt_out, 1);
    checkOutput("ptt_keyed_inhibit", tx_inhibit, 0);
    checkOutput("ptt_keyed_busy", busy, 0);
    tick(2);
    checkOutput("ptt_word", last_word, 16'h8810);

    // PTT release: ptt_out drops first, the T/R=0 frame loads one cycle later.
    applyStimulus(1'b1, 1'b0, 3'd4);
    tick(1);
    checkOutput("rel_out", ptt_out, 0);
    checkOutput("rel_wait_busy", busy, 0);
    tick(1);
    checkOutput("rel_load", busy, 1);
    tick(80);
    checkOutput("rel_word", last_word, 16'h0810);
    checkOutput("rel_inhibit", tx_inhibit, 0);

    // Two-cycle glitch to band 5 must not start a frame.
    applyStimulus(1'b1, 1'b0, 3'd5);
    tick(2);
    applyStimulus(1'b1, 1'b0, 3'd4);
    tick(10);
    checkOutput("glitch_busy", busy, 0);
    checkOutput("glitch_rck_count", rck_count, 4);
    checkOutput("glitch_band_active", band_active, 4);

    // Band 2 frame in flight, band 6 arrives during SHIFT: 0x0204 completes, then 0x2040.
    applyStimulus(1'b1, 1'b0, 3'd2);
    tick(10);
    checkOutput("mid_shift_busy", busy, 1);
    applyStimulus(1'b1, 1'b0, 3'd6);
    tick(72);
    checkOutput("mid_first_done", busy, 0);
    checkOutput("mid_first_word", last_word, 16'h0204);
    checkOutput("mid_first_band", band_active, 2);
    tick(1);
    checkOutput("mid_second_load", busy, 1);
    tick(80);
    checkOutput("mid_second_word", last_word, 16'h2040);
    checkOutput("mid_rck_count", rck_count, 6);
    checkOutput("mid_band_active", band_active, 6);

    // Back to band 4 and key up, then change band while transmitting.
    applyStimulus(1'b1, 1'b0, 3'd4);
    tick(85);
    checkOutput("tx_setup_word", last_word, 16'h0810);
    applyStimulus(1'b1, 1'b1, 3'd4);
    tick(80);
    checkOutput("tx_setup_out", ptt_out, 1);
    applyStimulus(1'b1, 1'b1, 3'd6);
    tick(4);
    checkOutput("tx_hold_out", ptt_out, 1);
    tick(1);
    checkOutput("tx_drop_out", ptt_out, 0);
    checkOutput("tx_drop_busy", busy, 1);
    checkOutput("tx_drop_inhibit", tx_inhibit, 1);
    tick(76);
    checkOutput("tx_wait_out", ptt_out, 0);
    checkOutput("tx_wait_inhibit", tx_inhibit, 1);
    tick(1);
    checkOutput("tx_rekey_out", ptt_out, 1);
    checkOutput("tx_rekey_inhibit", tx_inhibit, 0);
    tick(2);
    checkOutput("tx_word", last_word, 16'hA040);
    checkOutput("tx_rck_count", rck_count, 9);

    // Release PTT, then assert reset while bit 13 (a 1) is on sdo with sck high.
    applyStimulus(1'b1, 1'b0, 3'd6);
    tick(1);
    checkOutput("arst_pre_out", ptt_out, 0);
    tick(12);
    checkOutput("arst_pre_sck", sck, 1);
    checkOutput("arst_pre_sdo", sdo, 1);
    checkOutput("arst_pre_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    checkOutput("arst_sck", sck, 0);
    checkOutput("arst_sdo", sdo, 0);
    checkOutput("arst_rck", rck, 0);
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_ptt_out", ptt_out, 0);
    checkOutput("arst_band_active", band_active, 0);
    tick(2);
    reset_n = 1'b1;

    // After reset the band restarts at 0, so the band 0 word goes out before band 6 again.
    tick(1);
    checkOutput("resend_load", busy, 1);
    tick(77);
    checkOutput("resend_first_done", busy, 0);
    checkOutput("resend_first_word", last_word, 16'h0001);
    checkOutput("resend_first_bits", last_bits, 16);
    tick(1);
    checkOutput("resend_second_load", busy, 1);
    tick(80);
    checkOutput("resend_word", last_word, 16'h2040);
    checkOutput("resend_bits", last_bits, 16);
    checkOutput("resend_rck_count", rck_count, 11);
    checkOutput("resend_band_active", band_active, 6);
    checkOutput("resend_busy_len", last_busy, 77);
    checkOutput("sdo_stable_in_sck_high", sdo_glitch, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
